mem_req_ctrl: RTL and testbench

- Request-side controller directly upstream of the 64K x 8 parity memory (my_mem).
- Accepts read/write requests over a valid/ready handshake and drives the memory's write/read/address/data_in pins.
- Captures the 9-bit data_out on reads, checks bit 8 as parity, and returns read data plus an error flag over a valid/ready response channel.
- Keeps a saturating count of parity failures for status readout.

---
 rtl/mem_ctrl_pkg.sv | 20 ++
 rtl/mem_req_ctrl.sv | 154 +++++++++++++++
 tb/tb_mem_req_ctrl.sv | 296 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_ctrl_pkg.sv
// Shared types and helpers for the memory request controller.
// Holds default widths, the controller state encoding and the parity rule.
package mem_ctrl_pkg;

    localparam int ADDR_W_DEF = 16;
    localparam int DATA_W_DEF = 8;

    typedef enum logic [1:0] {
        IDLE,
        WR,
        RD_WAIT,
        RESP
    } state_e;

    // Zero-extension does not change an XOR reduction, so any data width up to 64 fits.
    function automatic logic calc_parity(input logic [63:0] data, input logic odd);
        return odd ? ~(^data) : (^data);
    endfunction

endpackage

// File: rtl/mem_req_ctrl.sv
// Request-side controller for a parity-protected memory: valid/ready requests in,
// single-cycle write pulses or latency-counted reads out, checked read data back.
module mem_req_ctrl
    import mem_ctrl_pkg::*;
#(
    parameter int   ADDR_W     = ADDR_W_DEF,
    parameter int   DATA_W     = DATA_W_DEF,
    parameter int   RD_LATENCY = 1,
    parameter logic PARITY_ODD = 1'b0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_write,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              rsp_parity_err,
    output logic              mem_write,
    output logic              mem_read,
    output logic [ADDR_W-1:0] mem_address,
    output logic [DATA_W-1:0] mem_data_in,
    input  logic [DATA_W:0]   mem_data_out,
    output logic [15:0]       err_count
);

    localparam logic [2:0] LAT = 3'(RD_LATENCY);

    state_e            r_state,          w_state_nxt;
    logic [2:0]        r_wait_cnt,       w_wait_cnt_nxt;
    logic              r_req_ready,      w_req_ready_nxt;
    logic              r_rsp_valid,      w_rsp_valid_nxt;
    logic [DATA_W-1:0] r_rsp_rdata,      w_rsp_rdata_nxt;
    logic              r_rsp_parity_err, w_rsp_parity_err_nxt;
    logic              r_mem_write,      w_mem_write_nxt;
    logic              r_mem_read,       w_mem_read_nxt;
    logic [ADDR_W-1:0] r_mem_address,    w_mem_address_nxt;
    logic [DATA_W-1:0] r_mem_data_in,    w_mem_data_in_nxt;
    logic [15:0]       r_err_count,      w_err_count_nxt;
    logic              w_bad_parity;

    assign w_bad_parity = mem_data_out[DATA_W]
                          != calc_parity(64'(mem_data_out[DATA_W-1:0]), PARITY_ODD);

    // NOTE: every next-value starts as "hold" so no path through the case leaves one unassigned (no latches).
    always_comb begin
        w_state_nxt          = r_state;
        w_wait_cnt_nxt       = r_wait_cnt;
        w_req_ready_nxt      = r_req_ready;
        w_rsp_valid_nxt      = r_rsp_valid;
        w_rsp_rdata_nxt      = r_rsp_rdata;
        w_rsp_parity_err_nxt = r_rsp_parity_err;
        w_mem_write_nxt      = r_mem_write;
        w_mem_read_nxt       = r_mem_read;
        w_mem_address_nxt    = r_mem_address;
        w_mem_data_in_nxt    = r_mem_data_in;
        w_err_count_nxt      = r_err_count;

        case (r_state)
            IDLE: begin
                if (req_valid) begin
                    w_req_ready_nxt   = 1'b0;
                    w_mem_address_nxt = req_addr;
                    if (req_write) begin
                        w_state_nxt       = WR;
                        w_mem_write_nxt   = 1'b1;
                        w_mem_data_in_nxt = req_wdata;
                    end else begin
                        w_state_nxt    = RD_WAIT;
                        w_mem_read_nxt = 1'b1;
                        w_wait_cnt_nxt = LAT;
                    end
                end
            end
            WR: begin
                w_state_nxt     = IDLE;
                w_mem_write_nxt = 1'b0;
                w_req_ready_nxt = 1'b1;
            end
            RD_WAIT: begin
                // The counter hits zero RD_LATENCY edges after the request edge; the next edge samples.
                if (r_wait_cnt == 3'd0) begin
                    w_state_nxt          = RESP;
                    w_mem_read_nxt       = 1'b0;
                    w_rsp_valid_nxt      = 1'b1;
                    w_rsp_rdata_nxt      = mem_data_out[DATA_W-1:0];
                    w_rsp_parity_err_nxt = w_bad_parity;
                    if (w_bad_parity && (r_err_count != 16'hFFFF))
                        w_err_count_nxt = r_err_count + 16'd1;
                end else begin
                    w_wait_cnt_nxt = r_wait_cnt - 3'd1;
                end
            end
            RESP: begin
                if (rsp_ready) begin
                    w_state_nxt          = IDLE;
                    w_rsp_valid_nxt      = 1'b0;
                    w_rsp_parity_err_nxt = 1'b0;
                    w_req_ready_nxt      = 1'b1;
                end
            end
            default: begin
                w_state_nxt     = IDLE;
                w_req_ready_nxt = 1'b1;
                w_mem_write_nxt = 1'b0;
                w_mem_read_nxt  = 1'b0;
                w_rsp_valid_nxt = 1'b0;
            end
        endcase
    end

    // NOTE: state registers use non-blocking assignments so all of them update together at the edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state          <= IDLE;
            r_wait_cnt       <= '0;
            r_req_ready      <= 1'b1;
            r_rsp_valid      <= 1'b0;
            r_rsp_rdata      <= '0;
            r_rsp_parity_err <= 1'b0;
            r_mem_write      <= 1'b0;
            r_mem_read       <= 1'b0;
            r_mem_address    <= '0;
            r_mem_data_in    <= '0;
            r_err_count      <= '0;
        end else begin
            r_state          <= w_state_nxt;
            r_wait_cnt       <= w_wait_cnt_nxt;
            r_req_ready      <= w_req_ready_nxt;
            r_rsp_valid      <= w_rsp_valid_nxt;
            r_rsp_rdata      <= w_rsp_rdata_nxt;
            r_rsp_parity_err <= w_rsp_parity_err_nxt;
            r_mem_write      <= w_mem_write_nxt;
            r_mem_read       <= w_mem_read_nxt;
            r_mem_address    <= w_mem_address_nxt;
            r_mem_data_in    <= w_mem_data_in_nxt;
            r_err_count      <= w_err_count_nxt;
        end
    end

    assign req_ready      = r_req_ready;
    assign rsp_valid      = r_rsp_valid;
    assign rsp_rdata      = r_rsp_rdata;
    assign rsp_parity_err = r_rsp_parity_err;
    assign mem_write      = r_mem_write;
    assign mem_read       = r_mem_read;
    assign mem_address    = r_mem_address;
    assign mem_data_in    = r_mem_data_in;
    assign err_count      = r_err_count;

endmodule

// File: tb/tb_mem_req_ctrl.sv
// Bench for mem_req_ctrl: one instance with read latency 1 and one with latency 3,
// both attached to a shared behavioural 64K x 9 memory; only the selected one is driven.
module tb_mem_req_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        sel;
    logic        req_valid, req_write, rsp_ready;
    logic [15:0] req_addr;
    logic [7:0]  req_wdata;

    logic        w_req_ready   [2];
    logic        w_rsp_valid   [2];
    logic [7:0]  w_rsp_rdata   [2];
    logic        w_rsp_perr    [2];
    logic        w_mem_write   [2];
    logic        w_mem_read    [2];
    logic [15:0] w_mem_address [2];
    logic [7:0]  w_mem_data_in [2];
    logic [15:0] w_err_count   [2];

    logic [8:0]  mem [0:65535];
    logic [8:0]  pipe1;
    logic [8:0]  pipe3 [3];
    logic        pl_en;
    logic [15:0] pl_addr;
    logic [8:0]  pl_word;

    int          n_tests = 0;
    int          n_fail  = 0;
    logic [8:0]  ref_word [logic [15:0]];
    int          exp_cnt  [2];

    always #5 clk = ~clk;

    mem_req_ctrl #(.RD_LATENCY(1)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid && !sel), .req_ready(w_req_ready[0]),
        .req_write(req_write), .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_valid(w_rsp_valid[0]), .rsp_ready(rsp_ready),
        .rsp_rdata(w_rsp_rdata[0]), .rsp_parity_err(w_rsp_perr[0]),
        .mem_write(w_mem_write[0]), .mem_read(w_mem_read[0]),
        .mem_address(w_mem_address[0]), .mem_data_in(w_mem_data_in[0]),
        .mem_data_out(pipe1), .err_count(w_err_count[0])
    );

    mem_req_ctrl #(.RD_LATENCY(3)) dut3 (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid && sel), .req_ready(w_req_ready[1]),
        .req_write(req_write), .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_valid(w_rsp_valid[1]), .rsp_ready(rsp_ready),
        .rsp_rdata(w_rsp_rdata[1]), .rsp_parity_err(w_rsp_perr[1]),
        .mem_write(w_mem_write[1]), .mem_read(w_mem_read[1]),
        .mem_address(w_mem_address[1]), .mem_data_in(w_mem_data_in[1]),
        .mem_data_out(pipe3[2]), .err_count(w_err_count[1])
    );

    // Memory: stores writes with even parity; read data appears after the configured latency.
    always @(posedge clk) begin
        if (pl_en) mem[pl_addr] <= pl_word;
        for (int k = 0; k < 2; k++)
            if (w_mem_write[k]) mem[w_mem_address[k]] <= {^w_mem_data_in[k], w_mem_data_in[k]};
        if (w_mem_read[0]) pipe1 <= mem[w_mem_address[0]];
        pipe3[0] <= w_mem_read[1] ? mem[w_mem_address[1]] : 9'h000;
        pipe3[1] <= pipe3[0];
        pipe3[2] <= pipe3[1];
    end

    logic        o_req_ready, o_rsp_valid, o_perr, o_mem_write, o_mem_read;
    logic [7:0]  o_rsp_rdata, o_mem_din;
    logic [15:0] o_mem_addr, o_err_count;
    assign o_req_ready = w_req_ready[sel];
    assign o_rsp_valid = w_rsp_valid[sel];
    assign o_rsp_rdata = w_rsp_rdata[sel];
    assign o_perr      = w_rsp_perr[sel];
    assign o_mem_write = w_mem_write[sel];
    assign o_mem_read  = w_mem_read[sel];
    assign o_mem_addr  = w_mem_address[sel];
    assign o_mem_din   = w_mem_data_in[sel];
    assign o_err_count = w_err_count[sel];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic wait_ready(input string tag);
        int n = 0;
        while (!o_req_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        check(tag, o_req_ready, 1);
    endtask

    task automatic preload(input logic [15:0] a, input logic [8:0] w);
        @(negedge clk);
        pl_en = 1'b1; pl_addr = a; pl_word = w;
        @(negedge clk);
        pl_en = 1'b0;
        ref_word[a] = w;
    endtask

    task automatic do_write(input logic [15:0] a, input logic [7:0] d);
        @(negedge clk);
        wait_ready("wr_ready");
        req_valid = 1'b1; req_write = 1'b1; req_addr = a; req_wdata = d;
        @(posedge clk); #1;
        check("wr_pulse", o_mem_write, 1);
        check("wr_no_read", o_mem_read, 0);
        check("wr_addr", o_mem_addr, a);
        check("wr_data", o_mem_din, d);
        check("wr_busy", o_req_ready, 0);
        @(negedge clk);
        req_valid = 1'b0;
        @(posedge clk); #1;
        check("wr_pulse_end", o_mem_write, 0);
        check("wr_ready_back", o_req_ready, 1);
        ref_word[a] = {^d, d};
    endtask

    // Reads one address; 'hold' cycles of response backpressure before accepting.
    task automatic do_read(input logic [15:0] a, input int hold);
        int         lat = sel ? 3 : 1;
        logic [8:0] w;
        logic [7:0] exp_rd;
        logic       exp_err;
        logic [7:0] din_before;
        w       = ref_word[a];
        exp_rd  = w[7:0];
        exp_err = (w[8] != ^w[7:0]);
        @(negedge clk);
        wait_ready("rd_ready");
        din_before = o_mem_din;
        req_valid = 1'b1; req_write = 1'b0; req_addr = a; req_wdata = 8'($urandom);
        @(posedge clk); #1;
        check("rd_start", o_mem_read, 1);
        check("rd_no_write", o_mem_write, 0);
        check("rd_addr", o_mem_addr, a);
        check("rd_din_kept", o_mem_din, din_before);
        @(negedge clk);
        req_valid = 1'b0;
        req_addr  = 16'($urandom);
        for (int i = 1; i <= lat; i++) begin
            @(posedge clk); #1;
            check("rd_wait_read", o_mem_read, 1);
            check("rd_wait_addr", o_mem_addr, a);
            check("rd_wait_novalid", o_rsp_valid, 0);
        end
        @(posedge clk); #1;
        if (exp_err && exp_cnt[sel] < 65535) exp_cnt[sel]++;
        check("rsp_valid", o_rsp_valid, 1);
        check("rsp_rdata", o_rsp_rdata, exp_rd);
        check("rsp_perr", o_perr, exp_err);
        check("rd_end", o_mem_read, 0);
        check("err_count", o_err_count, exp_cnt[sel]);
        for (int i = 0; i < hold; i++) begin
            @(posedge clk); #1;
            check("bp_valid", o_rsp_valid, 1);
            check("bp_rdata", o_rsp_rdata, exp_rd);
            check("bp_perr", o_perr, exp_err);
            check("bp_busy", o_req_ready, 0);
        end
        @(negedge clk);
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        check("rsp_done_valid", o_rsp_valid, 0);
        check("rsp_done_perr", o_perr, 0);
        check("rsp_rdata_kept", o_rsp_rdata, exp_rd);
        check("rsp_ready_back", o_req_ready, 1);
        @(negedge clk);
        rsp_ready = 1'b0;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_ready"}, o_req_ready, 1);
        check({tag, "_valid"}, o_rsp_valid, 0);
        check({tag, "_perr"}, o_perr, 0);
        check({tag, "_mwr"}, o_mem_write, 0);
        check({tag, "_mrd"}, o_mem_read, 0);
        check({tag, "_addr"}, o_mem_addr, 0);
        check({tag, "_din"}, o_mem_din, 0);
        check({tag, "_rdata"}, o_rsp_rdata, 0);
        check({tag, "_errcnt"}, o_err_count, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [15:0] ba [6];
        logic [7:0]  bd [6];
        logic        seen;
        int          n;

        sel = 1'b0; rst_n = 1'b0;
        req_valid = 1'b0; req_write = 1'b0; req_addr = '0; req_wdata = '0;
        rsp_ready = 1'b0; pl_en = 1'b0; pl_addr = '0; pl_word = '0;
        exp_cnt[0] = 0; exp_cnt[1] = 0;
        repeat (2) @(posedge clk);
        #1;
        check_reset_outputs("init");
        @(negedge clk);
        rst_n = 1'b1;

        // Write then read with correct parity.
        do_write(16'h1234, 8'hA5);
        do_read(16'h1234, 0);

        // Wrong parity stored at the top address.
        preload(16'hFFFF, 9'h1A5);
        do_read(16'hFFFF, 0);

        // Backpressure on the response channel.
        do_write(16'h0000, 8'h3C);
        do_read(16'h0000, 5);

        // Reset asserted while a read is waiting on the memory.
        @(negedge clk);
        wait_ready("rst_ready");
        req_valid = 1'b1; req_write = 1'b0; req_addr = 16'h1234;
        @(posedge clk); #1;
        check("rst_pre_read", o_mem_read, 1);
        #2 rst_n = 1'b0;
        #1;
        check_reset_outputs("async_rst");
        req_valid = 1'b0;
        exp_cnt[0] = 0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 8; i++) begin
            @(posedge clk); #1;
            seen = seen | o_rsp_valid | o_mem_read;
        end
        check("dropped_read_silent", seen, 0);
        check("rst_ready_after", o_req_ready, 1);

        // Back-to-back writes with req_valid held high.
        for (int i = 0; i < 6; i++) begin
            ba[i] = {13'($urandom), 3'(i)};
            bd[i] = 8'($urandom);
        end
        @(negedge clk);
        wait_ready("b2b_ready");
        req_valid = 1'b1; req_write = 1'b1; req_addr = ba[0]; req_wdata = bd[0];
        for (int i = 0; i < 6; i++) begin
            n = 0;
            do begin
                @(posedge clk); #1;
                n++;
            end while (!o_mem_write && n < 10);
            check("b2b_spacing", n, (i == 0) ? 1 : 2);
            check("b2b_addr", o_mem_addr, ba[i]);
            check("b2b_data", o_mem_din, bd[i]);
            ref_word[ba[i]] = {^bd[i], bd[i]};
            @(negedge clk);
            if (i < 5) begin
                req_addr = ba[i+1]; req_wdata = bd[i+1];
            end else begin
                req_valid = 1'b0;
            end
        end
        for (int i = 0; i < 6; i++) do_read(ba[i], 0);
        check("b2b_no_errors", o_err_count, 0);

        // Latency-3 instance: timing, then saturation of the error counter.
        sel = 1'b1;
        do_write(16'h5A5A, 8'h81);
        do_read(16'h5A5A, 1);
        preload(16'h0000, 9'h1A5);
        preload(16'h8001, 9'h001);
        preload(16'hFFFF, 9'h1A5);
        @(negedge clk);
        dut3.r_err_count = 16'hFFFC;
        exp_cnt[1] = 16'hFFFC;
        do_read(16'h0000, 0);
        do_read(16'h8001, 0);
        check("sat_at_fffe", o_err_count, 16'hFFFE);
        do_read(16'hFFFF, 0);
        check("sat_at_ffff", o_err_count, 16'hFFFF);
        do_read(16'h0000, 2);
        check("sat_holds", o_err_count, 16'hFFFF);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
